decode_issue: RTL

//  Front-end partner of the execute ALU: accepts fetched instruction words, decodes them into the

---
 rtl/decode_issue.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_issue.sv
// decode_issue: decodes fetched instruction words and buffers them in a
// 2-entry FIFO skid buffer ahead of the execute ALU. Enforces BAR (stall
// until barrier_release_i) and DONE (halt until reset).
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   instr_valid_i/_ready_o, instr_i, pc_i   fetch side handshake + payload
//   flush_i             taken branch/jump from execute, drops buffered entries
//   barrier_release_i   releases a pending BAR
//   issue_valid_o/issue_ready_i             execute side handshake
//   op_o, rd_addr_o, rs_addr_o, pc_o        decoded entry at the buffer head
//   writes_rd_o, is_branch_o, is_mem_o      control flags ({load,store} for is_mem_o)
//   halted_o            DONE has issued (or illegal trap taken)
//   illegal_o           sticky illegal-opcode flag
//
// Build option: define DECODE_ILLEGAL_TRAP_EN to trap unmatched opcodes
// (accepted, never issued, illegal_o set, core halts). Without it an unmatched
// opcode issues as a NOP bubble and illegal_o is tied low.

package decode_issue_pkg;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned PC_W      = 10;
  localparam int unsigned OPCODE_W  = INSTR_W - 2 * RF_ADDR_W;

  localparam logic [OPCODE_W-1:0] OP_ADDU  = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_SUBU  = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_SLLV  = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_SRAV  = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_SRLV  = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_NOR   = 6'd7;
  localparam logic [OPCODE_W-1:0] OP_SLT   = 6'd8;
  localparam logic [OPCODE_W-1:0] OP_SLTU  = 6'd9;
  localparam logic [OPCODE_W-1:0] OP_MOV   = 6'd10;
  localparam logic [OPCODE_W-1:0] OP_BAR   = 6'd11;
  localparam logic [OPCODE_W-1:0] OP_NOP   = 6'd12;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'd13;
  localparam logic [OPCODE_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'd15;
  localparam logic [OPCODE_W-1:0] OP_SB    = 6'd16;
  localparam logic [OPCODE_W-1:0] OP_JALR  = 6'd17;
  localparam logic [OPCODE_W-1:0] OP_BEQZ  = 6'd18;
  localparam logic [OPCODE_W-1:0] OP_BNEQZ = 6'd19;
  localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'd20;
  localparam logic [OPCODE_W-1:0] OP_BLTZ  = 6'd21;
  localparam logic [OPCODE_W-1:0] OP_DONE  = 6'd22;

  // Field order matches the raw instruction word: {op, rd, rs}.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs;
  } instruction_s;

  typedef struct packed {
    instruction_s     op;
    logic [PC_W-1:0]  pc;
    logic             writes_rd;
    logic             is_branch;
    logic [1:0]       is_mem;
    logic             is_done;
  } entry_s;
endpackage

module decode_issue
  import decode_issue_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [INSTR_W-1:0]   instr_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 flush_i,
  input  logic                 barrier_release_i,
  output logic                 issue_valid_o,
  input  logic                 issue_ready_i,
  output instruction_s         op_o,
  output logic [RF_ADDR_W-1:0] rd_addr_o,
  output logic [RF_ADDR_W-1:0] rs_addr_o,
  output logic [PC_W-1:0]      pc_o,
  output logic                 writes_rd_o,
  output logic                 is_branch_o,
  output logic [1:0]           is_mem_o,
  output logic                 halted_o,
  output logic                 illegal_o
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_RUN, ST_BAR_WAIT, ST_HALTED} state_e;

  state_e     state_q, state_d;
  logic [1:0] count_q, count_d;
  entry_s     head_q, head_d, tail_q, tail_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  entry_s     dec;
  logic       dec_bar, dec_illegal;
  logic       accept, pop, push;

  assign instr_ready_o = ~reset & (count_q < 2'd2) & (state_q == ST_RUN) & ~flush_i;

  // Combinational decode of the offered word.
  always_comb begin
    dec           = '0;
    dec_bar       = 1'b0;
    dec_illegal   = 1'b0;
    dec.op.opcode = instr_i[INSTR_W-1 -: OPCODE_W];
    dec.op.rd     = instr_i[2*RF_ADDR_W-1 -: RF_ADDR_W];
    dec.op.rs     = instr_i[RF_ADDR_W-1:0];
    dec.pc        = pc_i;
    casez (dec.op.opcode)
      OP_ADDU, OP_SUBU, OP_SLLV, OP_SRAV, OP_SRLV,
      OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU, OP_MOV: dec.writes_rd = 1'b1;
      OP_LW, OP_LBU: begin
        dec.writes_rd = 1'b1;
        dec.is_mem    = 2'b10;
      end
      OP_SW, OP_SB:  dec.is_mem = 2'b01;
      OP_JALR: begin
        dec.writes_rd = 1'b1;
        dec.is_branch = 1'b1;
      end
      OP_BEQZ, OP_BNEQZ, OP_BGTZ, OP_BLTZ: dec.is_branch = 1'b1;
      OP_BAR:  dec_bar = 1'b1;
      OP_DONE: dec.is_done = 1'b1;
      OP_NOP:  ;
      default: begin
        // Unmatched opcode: becomes a NOP bubble unless trapping.
        dec_illegal   = 1'b1;
        dec.op.opcode = OP_NOP;
      end
    endcase
  end

  // Next-state: FSM, skid buffer and sticky status flags.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    accept    = instr_valid_i & instr_ready_o;
    pop       = (count_q != 2'd0) & issue_ready_i;
    push      = accept & ~(TRAP_EN & dec_illegal);

    if (flush_i) begin
      // Flush wins over every other event; HALTED is not left.
      count_d = 2'd0;
      if (state_q == ST_BAR_WAIT) state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (TRAP_EN && dec_illegal)          state_d = ST_HALTED;
            else if (dec.is_done)                state_d = ST_HALTED;
            else if (dec_bar && !barrier_release_i) state_d = ST_BAR_WAIT;
          end
        end
        ST_BAR_WAIT: if (barrier_release_i) state_d = ST_RUN;
        ST_HALTED:   ;
        default:     state_d = ST_RUN;
      endcase

      if (TRAP_EN && accept && dec_illegal) begin
        illegal_d = 1'b1;
        halted_d  = 1'b1;
      end
      if (pop && head_q.is_done) halted_d = 1'b1;

      // Push and pop together only happen with exactly one entry held.
      case ({push, pop})
        2'b11: head_d = dec;
        2'b10: begin
          if (count_q == 2'd0) head_d = dec;
          else                 tail_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign issue_valid_o = (count_q != 2'd0);
  assign op_o          = head_q.op;
  assign rd_addr_o     = head_q.op.rd;
  assign rs_addr_o     = head_q.op.rs;
  assign pc_o          = head_q.pc;
  assign writes_rd_o   = head_q.writes_rd;
  assign is_branch_o   = head_q.is_branch;
  assign is_mem_o      = head_q.is_mem;
  assign halted_o      = halted_q;
  assign illegal_o     = illegal_q;

endmodule
